// File: rtl/i2s_adc_receiver.sv
// Purpose : I2S ADC deserialiser; oversamples BCLK/LRCK/DAT on CLOCK_50 and emits signed L/R pairs.
// Latency : sample_valid rises SYNC_STAGES+1 CLOCK_50 cycles after the LRCK fall that closes the right slot.
// Backpr. : none; outputs are a held pair plus a one-cycle strobe, and the consumer must sample on the strobe.
//
// Ports:
//   CLOCK_50, reset_n                    system clock, asynchronous active-low reset
//   AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT    asynchronous codec pins (LRCK low = left slot)
//   leftSampleOut, rightSampleOut        last complete stereo pair, updated together
//   sample_valid                         one-cycle strobe when a new pair is presented
//   lrck_sync                            synchronised LRCK (SYNC_STAGES+1 cycles of delay)
//   short_slot                           one-cycle strobe when a slot closes with fewer than DATA_WIDTH bits
module i2s_adc_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    input  logic                         AUD_BCLK,
    input  logic                         AUD_ADCLRCK,
    input  logic                         AUD_ADCDAT,
    output logic signed [DATA_WIDTH-1:0] leftSampleOut,
    output logic signed [DATA_WIDTH-1:0] rightSampleOut,
    output logic                         sample_valid,
    output logic                         lrck_sync,
    output logic                         short_slot
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_e;

    // Synchroniser chains: SYNC_STAGES metastability flops plus one flop for edge detection.
    logic [SYNC_STAGES:0]  bclk_pipe_q, bclk_pipe_d;
    logic [SYNC_STAGES:0]  lrck_pipe_q, lrck_pipe_d;
    logic [SYNC_STAGES:0]  dat_pipe_q,  dat_pipe_d;

    state_e                state_q,     state_d;
    logic                  chan_q,      chan_d;      // 0 = left slot, 1 = right slot
    logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [CNT_W-1:0]      bitcnt_q,    bitcnt_d;
    logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
    logic [DATA_WIDTH-1:0] left_out_q,  left_out_d;
    logic [DATA_WIDTH-1:0] right_out_q, right_out_d;
    logic                  valid_q,     valid_d;
    logic                  short_q,     short_d;

    logic                  bclk_rise;
    logic                  lrck_now;
    logic                  lrck_edge;
    logic                  dat_bit;
    logic [CNT_W-1:0]      pad_sh;
    logic [DATA_WIDTH-1:0] slot_word;
    logic                  slot_short;
    logic                  slot_runt;
    logic                  chan_mismatch;
    logic                  restart;

    always_comb begin
        bclk_pipe_d = {bclk_pipe_q[SYNC_STAGES-1:0], AUD_BCLK};
        lrck_pipe_d = {lrck_pipe_q[SYNC_STAGES-1:0], AUD_ADCLRCK};
        dat_pipe_d  = {dat_pipe_q[SYNC_STAGES-1:0],  AUD_ADCDAT};
    end

    assign bclk_rise = bclk_pipe_q[SYNC_STAGES-1] & ~bclk_pipe_q[SYNC_STAGES];
    assign lrck_now  = lrck_pipe_q[SYNC_STAGES-1];
    assign lrck_edge = lrck_now ^ lrck_pipe_q[SYNC_STAGES];
    // Data taken from the oldest stage: the value just before the synchronised BCLK rose,
    // which has been stable since the preceding BCLK fall.
    assign dat_bit   = dat_pipe_q[SYNC_STAGES];

    // Captured bits sit in the LSBs; left-justify them so a short slot is zero-padded below.
    assign pad_sh     = CNT_W'(DATA_WIDTH) - bitcnt_q;
    assign slot_word  = shreg_q << pad_sh;
    assign slot_short = (bitcnt_q < CNT_W'(DATA_WIDTH));
    // A legitimate edge always moves LRCK to the level of the opposite channel.
    assign chan_mismatch = (lrck_now == chan_q);
    // A slot closing before any data bit was captured is an LRCK glitch, not a real slot:
    // the frame is abandoned rather than emitting a garbage word.
    assign slot_runt  = (state_q == SKIP) || ((state_q == SHIFT) && (bitcnt_q == '0));

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        hold_left_d = hold_left_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        valid_d     = 1'b0;
        short_d     = 1'b0;
        restart     = 1'b0;

        if (state_q == IDLE) begin
            // Only a falling LRCK starts capture, so the first pair is always a full left+right frame.
            if (lrck_edge && !lrck_now) begin
                chan_d  = 1'b0;
                restart = 1'b1;
            end
        end else if (lrck_edge) begin
            if (slot_runt || chan_mismatch) begin
                state_d = IDLE;
            end else begin
                short_d = slot_short;
                if (!chan_q) begin
                    hold_left_d = slot_word;
                end else begin
                    left_out_d  = hold_left_q;
                    right_out_d = slot_word;
                    valid_d     = 1'b1;
                end
                chan_d  = ~chan_q;
                restart = 1'b1;
            end
        end else if (bclk_rise) begin
            if (state_q == SKIP) begin
                shreg_d  = '0;
                bitcnt_d = '0;
                state_d  = SHIFT;
            end else if (state_q == SHIFT) begin
                shreg_d  = {shreg_q[DATA_WIDTH-2:0], dat_bit};
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = HOLD;
                end
            end
            // HOLD: surplus LSBs of a wide slot are discarded.
        end

        // A bclk_rise coinciding with the slot edge is the skip bit of the new slot.
        if (restart) begin
            shreg_d  = '0;
            bitcnt_d = '0;
            state_d  = bclk_rise ? SHIFT : SKIP;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_pipe_q <= '0;
            lrck_pipe_q <= '0;
            dat_pipe_q  <= '0;
            state_q     <= IDLE;
            chan_q      <= 1'b0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            hold_left_q <= '0;
            left_out_q  <= '0;
            right_out_q <= '0;
            valid_q     <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            bclk_pipe_q <= bclk_pipe_d;
            lrck_pipe_q <= lrck_pipe_d;
            dat_pipe_q  <= dat_pipe_d;
            state_q     <= state_d;
            chan_q      <= chan_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            hold_left_q <= hold_left_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            valid_q     <= valid_d;
            short_q     <= short_d;
        end
    end

    assign leftSampleOut  = left_out_q;
    assign rightSampleOut = right_out_q;
    assign sample_valid   = valid_q;
    assign short_slot     = short_q;
    assign lrck_sync      = lrck_pipe_q[SYNC_STAGES];

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Purpose : self-checking bench for i2s_adc_receiver; slot-level model of expected pairs and short slots.
// Latency : checks SYNC_STAGES+1 cycles from closing LRCK fall to sample_valid.
// Backpr. : none; every presented pair is consumed by the bench monitor.
module tb_i2s_adc_receiver;

    localparam int DW = 16;
    localparam int SS = 2;

    logic          CLOCK_50    = 1'b0;
    logic          reset_n     = 1'b0;
    logic          AUD_BCLK    = 1'b0;
    logic          AUD_ADCLRCK = 1'b0;
    logic          AUD_ADCDAT  = 1'b0;
    logic [DW-1:0] leftSampleOut;
    logic [DW-1:0] rightSampleOut;
    logic          sample_valid;
    logic          lrck_sync;
    logic          short_slot;

    always #10 CLOCK_50 = ~CLOCK_50;

    i2s_adc_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset_n        (reset_n),
        .AUD_BCLK       (AUD_BCLK),
        .AUD_ADCLRCK    (AUD_ADCLRCK),
        .AUD_ADCDAT     (AUD_ADCDAT),
        .leftSampleOut  (leftSampleOut),
        .rightSampleOut (rightSampleOut),
        .sample_valid   (sample_valid),
        .lrck_sync      (lrck_sync),
        .short_slot     (short_slot)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            hb = 8;              // BCLK half period in CLOCK_50 cycles
    int            short_seen = 0;
    int            short_exp = 0;
    int            valid_cnt = 0;
    int            last_valid_cyc = 0;
    int            last_fall_cyc = 0;
    logic [DW-1:0] exp_l_q[$];
    logic [DW-1:0] exp_r_q[$];
    logic [DW-1:0] cur_l = '0;
    logic [DW-1:0] cur_r = '0;
    logic [3:0]    hist = '0;           // AUD_ADCLRCK as sampled on recent falling clock edges

    task automatic check16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One clock: monitor on the falling edge, then return 2 ns after the rising edge for driving.
    task automatic tick();
        @(negedge CLOCK_50);
        if (!reset_n) begin
            cur_l = '0;
            cur_r = '0;
            hist  = '0;
            check16("reset_left", leftSampleOut, '0);
            check16("reset_right", rightSampleOut, '0);
            check_int("reset_ctl", int'({sample_valid, short_slot, lrck_sync}), 0);
        end else begin
            if (sample_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                check_int("valid_has_pair", int'(exp_l_q.size() != 0), 1);
                if (exp_l_q.size() != 0) begin
                    cur_l = exp_l_q.pop_front();
                    cur_r = exp_r_q.pop_front();
                end
            end
            check16("left_out", leftSampleOut, cur_l);
            check16("right_out", rightSampleOut, cur_r);
            check_int("lrck_sync", int'(lrck_sync), int'(hist[SS]));
            hist = {hist[2:0], AUD_ADCLRCK};
            if (short_slot) short_seen++;
        end
        @(posedge CLOCK_50);
        #2;
        cyc++;
    endtask

    function automatic logic [DW-1:0] trunc_word(input logic [DW-1:0] w, input int n);
        if (n >= DW) return w;
        return (w >> (DW - n)) << (DW - n);
    endfunction

    function automatic logic rbit();
        bit [31:0] rv;
        rv = $urandom();
        return rv[0];
    endfunction

    function automatic logic [DW-1:0] rword();
        bit [31:0] rv;
        rv = $urandom();
        return rv[DW-1:0];
    endfunction

    task automatic set_lr(input logic lr);
        if (AUD_ADCLRCK && !lr) last_fall_cyc = cyc;
        AUD_ADCLRCK = lr;
    endtask

    // One BCLK period: data and (normally) LRCK change with the falling edge.
    task automatic send_bit(input logic lr, input logic d, input bit lr_at_rise);
        AUD_BCLK   = 1'b0;
        AUD_ADCDAT = d;
        if (!lr_at_rise) set_lr(lr);
        repeat (hb) tick();
        AUD_BCLK = 1'b1;
        if (lr_at_rise) set_lr(lr);
        repeat (hb) tick();
    endtask

    // Skip bit followed by ndata data bits, MSB first; bits beyond DW are random filler.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int ndata, input bit simul);
        send_bit(lr, rbit(), simul);
        for (int i = 0; i < ndata; i++) begin
            send_bit(lr, (i < DW) ? w[DW-1-i] : rbit(), 1'b0);
        end
    endtask

    // A frame followed by another falling LRCK closes both slots and yields one pair.
    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int nl, input int nr, input bit simul);
        send_slot(1'b0, l, nl, simul);
        send_slot(1'b1, r, nr, simul);
        exp_l_q.push_back(trunc_word(l, nl));
        exp_r_q.push_back(trunc_word(r, nr));
        short_exp += int'(nl < DW) + int'(nr < DW);
    endtask

    task automatic do_reset(input logic lr);
        reset_n     = 1'b0;
        AUD_ADCLRCK = lr;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        short_seen = 0;
        short_exp  = 0;
        valid_cnt  = 0;
        exp_l_q.delete();
        exp_r_q.delete();
    endtask

    task automatic preamble();
        send_slot(1'b1, rword(), int'($urandom_range(3, 10)), 1'b0);
    endtask

    task automatic end_scen(input string name, input int nvalid, input bit simul);
        send_slot(1'b0, rword(), DW, simul);   // terminator: its falling LRCK closes the last right slot
        repeat (40) tick();
        check_int({name, "_pending"}, exp_l_q.size(), 0);
        check_int({name, "_valid_cnt"}, valid_cnt, nvalid);
        check_int({name, "_short_cnt"}, short_seen, short_exp);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;

        tick();

        // Nominal frame, BCLK = CLOCK_50/16, 32-BCLK slots.
        hb = 8;
        do_reset(1'b0);
        preamble();
        send_frame(16'h8001, 16'h7FFE, 31, 31, 1'b0);
        end_scen("nominal", 1, 1'b0);
        check16("nominal_left", leftSampleOut, 16'h8001);
        check16("nominal_right", rightSampleOut, 16'h7FFE);
        check_int("nominal_latency", last_valid_cyc - last_fall_cyc, SS + 1);
        check_int("nominal_short", short_seen, 0);

        // Short slots: 12 data bits per slot.
        hb = int'($urandom_range(2, 8));
        do_reset(1'b0);
        preamble();
        send_frame(16'hABC0, 16'h1230, 12, 12, 1'b0);
        end_scen("short", 1, 1'b0);
        check16("short_left", leftSampleOut, 16'hABC0);
        check16("short_right", rightSampleOut, 16'h1230);
        check_int("short_pulses", short_seen, 2);

        // Start inside a right slot after reset; only complete frames are output.
        hb = 3;
        do_reset(1'b1);
        preamble();
        for (int f = 0; f < 3; f++) begin
            send_frame(rword(), rword(), DW, DW, 1'b0);
        end
        end_scen("midright", 3, 1'b0);

        // LRCK edge coincident with BCLK rise for three frames.
        hb = 4;
        do_reset(1'b0);
        preamble();
        for (int f = 0; f < 3; f++) begin
            send_frame(16'h0F0F, 16'hF0F0, DW, DW, 1'b1);
        end
        end_scen("simul", 3, 1'b1);
        check16("simul_left", leftSampleOut, 16'h0F0F);
        check16("simul_right", rightSampleOut, 16'hF0F0);

        // Reset at bit 7 of a left slot; next output is the following full frame.
        hb = 3;
        do_reset(1'b0);
        preamble();
        send_frame(16'h1234, 16'hFEDC, DW, DW, 1'b0);
        send_bit(1'b0, rbit(), 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, rbit(), 1'b0);
        check16("prereset_left", leftSampleOut, 16'h1234);
        reset_n = 1'b0;
        #1;
        check16("async_rst_left", leftSampleOut, '0);
        check16("async_rst_right", rightSampleOut, '0);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 7; i < DW; i++) send_bit(1'b0, rbit(), 1'b0);
        send_slot(1'b1, rword(), DW, 1'b0);
        ra = rword();
        rb = rword();
        send_frame(ra, rb, DW, DW, 1'b0);
        end_scen("midreset", 2, 1'b0);
        check16("midreset_left", leftSampleOut, ra);
        check16("midreset_right", rightSampleOut, rb);

        // One-BCLK LRCK pulse inside a left slot after 5 data bits.
        hb = 2;
        do_reset(1'b0);
        preamble();
        send_frame(16'h5A5A, 16'hA5A5, DW, DW, 1'b0);
        send_bit(1'b0, rbit(), 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, rbit(), 1'b0);
        send_bit(1'b1, rbit(), 1'b0);
        short_exp += 1;   // the left slot closes short at the glitch's rising edge
        for (int i = 0; i < 8; i++) send_bit(1'b0, rbit(), 1'b0);
        send_slot(1'b1, rword(), DW, 1'b0);
        send_frame(16'h3C3C, 16'hC3C3, DW, DW, 1'b0);
        end_scen("glitch", 2, 1'b0);
        check16("glitch_left", leftSampleOut, 16'h3C3C);
        check16("glitch_right", rightSampleOut, 16'hC3C3);

        // Randomised frames: widths, BCLK rate, data and edge alignment.
        do_reset(1'b0);
        hb = int'($urandom_range(2, 6));
        preamble();
        for (int f = 0; f < 6; f++) begin
            hb = int'($urandom_range(2, 6));
            send_frame(rword(), rword(), int'($urandom_range(4, 24)),
                       int'($urandom_range(4, 24)), bit'(rbit()));
        end
        end_scen("random", 6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_adc_receiver.md
Name: i2s_adc_receiver

Overview:
- Deserialises the codec's I2S ADC stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) into parallel signed left/right samples.
- Feeds leftSampleIn/rightSampleIn of the effect stages, including chorus.
- Runs on the system clock. All codec pins are treated as asynchronous and oversampled.
- Presents each stereo pair atomically, with a one-cycle valid strobe.

Parameters:
- DATA_WIDTH, 16: sample width in bits, MSB first on the wire.
- SYNC_STAGES, 2: synchroniser flops per codec input (minimum 2).

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- AUD_BCLK  in  1  codec bit clock; asynchronous; at most CLOCK_50/4.
- AUD_ADCLRCK  in  1  codec frame clock; low = left slot, high = right slot.
- AUD_ADCDAT  in  1  codec serial data; changes on BCLK falling edge.
- leftSampleOut  out  DATA_WIDTH  last complete left sample, signed.
- rightSampleOut  out  DATA_WIDTH  last complete right sample, signed.
- sample_valid  out  1  one-cycle pulse when a new L/R pair is presented.
- lrck_sync  out  1  synchronised AUD_ADCLRCK, for downstream frame timing.
- short_slot  out  1  one-cycle pulse when a slot ends before DATA_WIDTH bits have been captured.

Behaviour:
- Reset (asynchronous, reset_n low):
  - leftSampleOut = 0, rightSampleOut = 0, sample_valid = 0, short_slot = 0, lrck_sync = 0.
  - Shift register, bit counter, synchronisers and left holding register all cleared.
  - FSM goes to IDLE.
- Reset deassertion needs no special alignment; the design relies on IDLE to find the first clean frame edge.
- Input handling:
  - Each codec input passes through SYNC_STAGES flops, plus one extra flop for edge detection.
  - bclk_rise = synchronised BCLK goes 0 to 1.
  - lrck_edge = synchronised LRCK changes. It is evaluated every cycle, independent of BCLK.
- Sampling: AUD_ADCDAT is sampled only on bclk_rise, using the synchronised data delayed to match BCLK.
- I2S framing: the MSB arrives on the 2nd bclk_rise after an LRCK transition. The 1st bclk_rise after the transition is the skip bit.
- FSM states: IDLE, SKIP, SHIFT, HOLD.
  - IDLE: wait for an lrck_edge where LRCK falls 1 to 0 (start of left). Go to SKIP with channel = left. Rising edges in IDLE are ignored, so output always starts on a left slot.
  - SKIP: on bclk_rise, clear the shift register and set bitcnt = 0, then go to SHIFT.
  - SHIFT: on each bclk_rise, shift in DATA_WIDTH-1 down to 0 and increment bitcnt. When bitcnt reaches DATA_WIDTH, go to HOLD.
  - HOLD: ignore further bclk_rise. This handles slots wider than DATA_WIDTH; extra LSBs are discarded.
  - On lrck_edge in SKIP, SHIFT or HOLD, the slot closes:
    - If bitcnt < DATA_WIDTH, zero-pad the remaining LSBs (word = shreg << (DATA_WIDTH - bitcnt)) and pulse short_slot.
    - If the closing channel is left, latch the word into the left holding register.
    - If the closing channel is right, in the same cycle load leftSampleOut from the holding register and rightSampleOut from the word, and pulse sample_valid.
    - Toggle the channel and go to SKIP.
- Simultaneous lrck_edge and bclk_rise in the same cycle: the slot close and restart take priority. That bclk_rise counts as the SKIP bit of the new slot.
- Mid-frame LRCK direction mismatch: if the LRCK level after an edge disagrees with the tracked channel (glitch or lost edge), the current slot is discarded without any output update. The FSM returns to IDLE.
- Outputs update only on sample_valid and are held stable for the whole next frame. Left and right always come from the same frame.
- Latency: sample_valid asserts SYNC_STAGES+1 CLOCK_50 cycles after the AUD_ADCLRCK rising-to-falling transition that ends the right slot.
- lrck_sync = synchronised LRCK, with the same SYNC_STAGES+1 delay.
- reset_n asserted mid-slot: immediate clear to reset values. The next output comes only after a full fresh left+right frame.

Test Plan:
- Nominal frame: BCLK = CLOCK_50/16, 32-bit slots, left = 16'h8001, right = 16'h7FFE. Result: one sample_valid pulse; leftSampleOut = 16'h8001, rightSampleOut = 16'h7FFE; no short_slot.
- Short slot: 12 BCLKs per slot, left bits 12'hABC, right 12'h123. Result: leftSampleOut = 16'hABC0, rightSampleOut = 16'h1230; short_slot pulses twice.
- Start mid-right-slot after reset: the partial first frame produces no sample_valid. The first sample_valid carries the first complete left/right pair.
- Simultaneous edges: align the BCLK and LRCK synchronised edges in the same cycle over 3 frames, data 16'h0F0F / 16'hF0F0. Result: exact values with no bit shift.
- Reset mid-SHIFT: assert reset_n low at bit 7 of the left slot. Result: outputs go to 0 asynchronously; the next valid pair matches the following full frame.
- LRCK glitch: insert a 1-BCLK LRCK pulse inside a left slot. Result: no sample_valid for that frame; the FSM recovers and the following frame outputs correctly.
